// File: rtl/ysyx_22050133_mem_arb_if.sv
// Request/response bundle shared by the IFU, LSU and memory sides of the arbiter.
// The requester (or the arbiter toward memory) is the master.
interface ysyx_22050133_mem_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask, rsp_ready,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, rsp_ready,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/ysyx_22050133_mem_arb.sv
// IFU/LSU memory port arbiter, one outstanding transaction.
// LSU has priority but never wins twice in a row over a waiting IFU.
module ysyx_22050133_mem_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22050133_mem_arb_if.slave  ifu_bus,
    ysyx_22050133_mem_arb_if.slave  lsu_bus,
    ysyx_22050133_mem_arb_if.master mem_bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_e;

    state_e              state_q;
    logic                owner_q;
    logic                last_lsu_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_req_valid_q;
    logic                mem_rsp_ready_q;
    logic                ifu_rsp_valid_q;
    logic                lsu_rsp_valid_q;

    logic                sel_ifu;
    logic                sel_lsu;
    logic                idle;
    logic                owner_rsp_ready;

    // owner_q / last_lsu_q: 1 = LSU, 0 = IFU
    always_comb begin
        sel_lsu = lsu_bus.req_valid
                & (~ifu_bus.req_valid | ~last_lsu_q);
        sel_ifu = ifu_bus.req_valid & ~sel_lsu;
    end

    assign idle = (state_q == IDLE);

    // Gated by rst so nothing is offered while held in reset
    assign ifu_bus.req_ready = rst & idle & sel_ifu;
    assign lsu_bus.req_ready = rst & idle & sel_lsu;

    assign owner_rsp_ready = owner_q ? lsu_bus.rsp_ready
                                     : ifu_bus.rsp_ready;

    assign mem_bus.req_valid = mem_req_valid_q;
    assign mem_bus.addr      = addr_q;
    assign mem_bus.wen       = wen_q;
    assign mem_bus.wdata     = wdata_q;
    assign mem_bus.wmask     = wmask_q;
    assign mem_bus.rsp_ready = mem_rsp_ready_q;

    assign ifu_bus.rsp_valid = ifu_rsp_valid_q;
    assign ifu_bus.rdata     = rdata_q;
    assign lsu_bus.rsp_valid = lsu_rsp_valid_q;
    assign lsu_bus.rdata     = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_lsu_q      <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            rdata_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_rsp_ready_q <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_lsu) begin
                        owner_q         <= 1'b1;
                        last_lsu_q      <= 1'b1;
                        addr_q          <= lsu_bus.addr;
                        wen_q           <= lsu_bus.wen;
                        wdata_q         <= lsu_bus.wdata;
                        wmask_q         <= lsu_bus.wmask;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end else if (sel_ifu) begin
                        owner_q         <= 1'b0;
                        last_lsu_q      <= 1'b0;
                        addr_q          <= ifu_bus.addr;
                        wen_q           <= 1'b0;
                        wdata_q         <= '0;
                        wmask_q         <= '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_bus.req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_rsp_ready_q <= 1'b1;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_bus.rsp_valid) begin
                        rdata_q         <= mem_bus.rdata;
                        mem_rsp_ready_q <= 1'b0;
                        ifu_rsp_valid_q <= ~owner_q;
                        lsu_rsp_valid_q <= owner_q;
                        state_q         <= RSP;
                    end
                end
                RSP: begin
                    if (owner_rsp_ready) begin
                        ifu_rsp_valid_q <= 1'b0;
                        lsu_rsp_valid_q <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
